// File: rtl/alu_digit_serial_if.sv
// Operand/result handshake bundle for the digit-serial ALU.
// slave = ALU side, master = producer/consumer side.
interface alu_digit_serial_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [2:0]       in_op;
  logic             in_cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_cout;
  logic             out_ovf;
  logic             out_zero;
  logic             busy;

  modport slave (
    input  in_valid, in_a, in_b, in_op, in_cin,
    input  out_ready,
    output in_ready, out_valid, out_result,
    output out_cout, out_ovf, out_zero, busy
  );

  modport master (
    output in_valid, in_a, in_b, in_op, in_cin,
    output out_ready,
    input  in_ready, out_valid, out_result,
    input  out_cout, out_ovf, out_zero, busy
  );
endinterface

// File: rtl/alu_digit_serial.sv
// Digit-serial ALU: WIDTH-bit operands, DIGIT bits per cycle, LSB first,
// carry registered between digit cycles, valid/ready on both sides.
module alu_digit_serial #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic clk,
  input  logic rst,
  alu_digit_serial_if.slave bus
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_AND   = 3'b010;
  localparam logic [2:0] OP_OR    = 3'b011;
  localparam logic [2:0] OP_XOR   = 3'b100;
  localparam logic [2:0] OP_PASS  = 3'b101;
  localparam logic [2:0] OP_CARRY = 3'b110;
  localparam logic [2:0] OP_RSVD  = 3'b111;

  generate
    if (DIGIT < 1 || WIDTH % DIGIT != 0) begin : g_bad_digit
      $error("alu_digit_serial: WIDTH must be a multiple of DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] a_q, b_q, res_q, res_d;
  logic [2:0]       op_q;
  logic             cin_q;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic             cout_q, ovf_q;

  logic             last;
  logic             sub;
  logic [DIGIT-1:0] da, db, dres;
  logic [DIGIT:0]   sum;
  logic             c_msb;
  logic             c_next;
  logic             arith;

  assign last = (cnt_q == CW'(NDIG - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid) state_d = RUN;
      RUN:     if (last) state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state_q == IDLE);
    bus.out_valid = (state_q == DONE);
    bus.busy      = (state_q != IDLE);
  end

  // One digit slice; carry into the digit MSB recovered from the sum bit.
  always_comb begin
    sub    = (op_q == OP_SUB);
    arith  = (op_q == OP_ADD) || sub;
    da     = a_q[DIGIT-1:0];
    db     = sub ? ~b_q[DIGIT-1:0] : b_q[DIGIT-1:0];
    sum    = {1'b0, da} + {1'b0, db} + {{DIGIT{1'b0}}, carry_q};
    c_msb  = sum[DIGIT-1] ^ da[DIGIT-1] ^ db[DIGIT-1];
    dres   = '0;
    c_next = 1'b0;
    case (op_q)
      OP_ADD:   begin dres = sum[DIGIT-1:0]; c_next = sum[DIGIT]; end
      OP_SUB:   begin dres = sum[DIGIT-1:0]; c_next = sum[DIGIT]; end
      OP_AND:   dres = da & db;
      OP_OR:    dres = da | db;
      OP_XOR:   dres = da ^ db;
      OP_PASS:  dres = da;
      OP_CARRY: c_next = sum[DIGIT];
      OP_RSVD:  dres = '0;
      default:  dres = '0;
    endcase
  end

  generate
    if (NDIG == 1) begin : g_one
      assign res_d = dres;
    end else begin : g_many
      assign res_d = {dres, res_q[WIDTH-1:DIGIT]};
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      op_q    <= '0;
      cin_q   <= 1'b0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            a_q     <= bus.in_a;
            b_q     <= bus.in_b;
            op_q    <= bus.in_op;
            cin_q   <= bus.in_cin;
            carry_q <= bus.in_cin;
            cnt_q   <= '0;
          end
        end
        RUN: begin
          a_q     <= a_q >> DIGIT;
          b_q     <= b_q >> DIGIT;
          res_q   <= res_d;
          carry_q <= c_next;
          cnt_q   <= cnt_q + CW'(1);
          if (last) begin
            cout_q <= (op_q == OP_RSVD) ? cin_q : c_next;
            ovf_q  <= arith & (c_msb ^ sum[DIGIT]);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.out_result = res_q;
    bus.out_cout   = cout_q;
    bus.out_ovf    = ovf_q;
    bus.out_zero   = (state_q == DONE) && (res_q == '0);
  end

endmodule

// File: tb/tb_alu_digit_serial.sv
// Bench for alu_digit_serial: directed cases plus random ops on four
// WIDTH/DIGIT configurations against an integer reference model.
module tb_alu_digit_serial;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_chk  = 0;

  logic        drv_valid = 1'b0;
  logic [15:0] drv_a     = '0;
  logic [15:0] drv_b     = '0;
  logic [2:0]  drv_op    = '0;
  logic        drv_cin   = 1'b0;
  logic        drv_ready = 1'b0;
  int          sel       = 0;

  alu_digit_serial_if #(.WIDTH(16)) if0 ();
  alu_digit_serial_if #(.WIDTH(16)) if1 ();
  alu_digit_serial_if #(.WIDTH(16)) if2 ();
  alu_digit_serial_if #(.WIDTH(8))  if3 ();

  alu_digit_serial #(.WIDTH(16), .DIGIT(4))
    u0 (.clk(clk), .rst(rst), .bus(if0));
  alu_digit_serial #(.WIDTH(16), .DIGIT(1))
    u1 (.clk(clk), .rst(rst), .bus(if1));
  alu_digit_serial #(.WIDTH(16), .DIGIT(16))
    u2 (.clk(clk), .rst(rst), .bus(if2));
  alu_digit_serial #(.WIDTH(8), .DIGIT(2))
    u3 (.clk(clk), .rst(rst), .bus(if3));

  assign if0.in_valid  = drv_valid && sel == 0;
  assign if1.in_valid  = drv_valid && sel == 1;
  assign if2.in_valid  = drv_valid && sel == 2;
  assign if3.in_valid  = drv_valid && sel == 3;
  assign if0.out_ready = drv_ready && sel == 0;
  assign if1.out_ready = drv_ready && sel == 1;
  assign if2.out_ready = drv_ready && sel == 2;
  assign if3.out_ready = drv_ready && sel == 3;
  assign if0.in_a = drv_a;
  assign if1.in_a = drv_a;
  assign if2.in_a = drv_a;
  assign if3.in_a = drv_a[7:0];
  assign if0.in_b = drv_b;
  assign if1.in_b = drv_b;
  assign if2.in_b = drv_b;
  assign if3.in_b = drv_b[7:0];
  assign if0.in_op = drv_op;
  assign if1.in_op = drv_op;
  assign if2.in_op = drv_op;
  assign if3.in_op = drv_op;
  assign if0.in_cin = drv_cin;
  assign if1.in_cin = drv_cin;
  assign if2.in_cin = drv_cin;
  assign if3.in_cin = drv_cin;

  logic        o_rdy  [4];
  logic        o_vld  [4];
  logic [15:0] o_res  [4];
  logic        o_cout [4];
  logic        o_ovf  [4];
  logic        o_zero [4];
  logic        o_busy [4];

  assign o_rdy[0] = if0.in_ready;
  assign o_rdy[1] = if1.in_ready;
  assign o_rdy[2] = if2.in_ready;
  assign o_rdy[3] = if3.in_ready;
  assign o_vld[0] = if0.out_valid;
  assign o_vld[1] = if1.out_valid;
  assign o_vld[2] = if2.out_valid;
  assign o_vld[3] = if3.out_valid;
  assign o_res[0] = if0.out_result;
  assign o_res[1] = if1.out_result;
  assign o_res[2] = if2.out_result;
  assign o_res[3] = {8'h00, if3.out_result};
  assign o_cout[0] = if0.out_cout;
  assign o_cout[1] = if1.out_cout;
  assign o_cout[2] = if2.out_cout;
  assign o_cout[3] = if3.out_cout;
  assign o_ovf[0] = if0.out_ovf;
  assign o_ovf[1] = if1.out_ovf;
  assign o_ovf[2] = if2.out_ovf;
  assign o_ovf[3] = if3.out_ovf;
  assign o_zero[0] = if0.out_zero;
  assign o_zero[1] = if1.out_zero;
  assign o_zero[2] = if2.out_zero;
  assign o_zero[3] = if3.out_zero;
  assign o_busy[0] = if0.busy;
  assign o_busy[1] = if1.busy;
  assign o_busy[2] = if2.busy;
  assign o_busy[3] = if3.busy;

  // Reference: whole-word arithmetic, overflow from operand/result signs.
  function automatic void model(
    input int w, input logic [15:0] a, input logic [15:0] b,
    input logic [2:0] op, input logic cin,
    output logic [15:0] r, output logic c,
    output logic v, output logic z);
    longint m, aa, bb, s, rr;
    m  = (longint'(1) << w) - 1;
    aa = longint'(a) & m;
    bb = longint'(b) & m;
    rr = 0;
    c  = 1'b0;
    v  = 1'b0;
    if (op == 3'd1) bb = (~bb) & m;
    s = aa + bb + longint'(cin);
    case (op)
      3'd0, 3'd1: begin
        rr = s & m;
        c  = s[w];
        v  = (aa[w-1] == bb[w-1]) && (rr[w-1] != aa[w-1]);
      end
      3'd2: rr = aa & bb;
      3'd3: rr = aa | bb;
      3'd4: rr = aa ^ bb;
      3'd5: rr = aa;
      3'd6: c = s[w];
      default: c = cin;
    endcase
    r = 16'(rr);
    z = (rr == 0);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input int k, input logic [15:0] a,
                       input logic [15:0] b, input logic [2:0] op,
                       input logic cin, output int lat);
    int t;
    t = 0;
    while (!o_rdy[k] && t < 40) begin
      step();
      t++;
    end
    sel       = k;
    drv_a     = a;
    drv_b     = b;
    drv_op    = op;
    drv_cin   = cin;
    drv_valid = 1'b1;
    step();
    drv_valid = 1'b0;
    drv_a     = 16'($urandom);
    drv_b     = 16'($urandom);
    lat = 0;
    while (!o_vld[k] && lat < 40) begin
      step();
      lat++;
    end
  endtask

  task automatic finish_op(input int k);
    sel       = k;
    drv_ready = 1'b1;
    step();
    drv_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    for (int k = 0; k < 4; k++) begin
      n_chk++;
      if ({o_rdy[k], o_vld[k], o_res[k], o_cout[k], o_ovf[k],
           o_zero[k], o_busy[k]} !== {1'b1, 1'b0, 16'h0, 4'h0}) begin
        $display("FAIL reset_values cfg%0d got rdy=%b vld=%b res=%h c=%b v=%b z=%b busy=%b want 1 0 0000 0 0 0 0",
                 k, o_rdy[k], o_vld[k], o_res[k], o_cout[k],
                 o_ovf[k], o_zero[k], o_busy[k]);
      end else n_pass++;
    end
    rst = 1'b0;
    step();
    step();
    n_chk++;
    if ({o_rdy[0], o_vld[0], o_busy[0]} !== 3'b100) begin
      $display("FAIL idle_after_reset got rdy/vld/busy=%b%b%b want 100",
               o_rdy[0], o_vld[0], o_busy[0]);
    end else n_pass++;
  endtask

  task automatic test_directed(input string name, input logic [15:0] a,
                               input logic [15:0] b, input logic [2:0] op,
                               input logic cin, input logic [15:0] er,
                               input logic ec, input logic ev,
                               input logic ez);
    int lat;
    do_op(0, a, b, op, cin, lat);
    n_chk++;
    if (lat !== 4) begin
      $display("FAIL %s_latency got %0d want 4", name, lat);
    end else n_pass++;
    n_chk++;
    if ({o_res[0], o_cout[0], o_ovf[0], o_zero[0]} !== {er, ec, ev, ez}) begin
      $display("FAIL %s_result got res=%h c=%b v=%b z=%b want res=%h c=%b v=%b z=%b",
               name, o_res[0], o_cout[0], o_ovf[0], o_zero[0],
               er, ec, ev, ez);
    end else n_pass++;
    finish_op(0);
  endtask

  task automatic test_backpressure();
    int lat;
    logic [18:0] held;
    do_op(0, 16'h1234, 16'h4321, 3'd0, 1'b0, lat);
    held = {o_res[0], o_cout[0], o_ovf[0], o_zero[0]};
    n_chk++;
    if (held !== {16'h5555, 3'b000}) begin
      $display("FAIL bp_result got %h want %h", held, {16'h5555, 3'b000});
    end else n_pass++;
    for (int i = 0; i < 10; i++) begin
      drv_valid = (i == 3);
      drv_a     = 16'hFFFF;
      drv_op    = 3'd2;
      step();
      n_chk++;
      if ({o_res[0], o_cout[0], o_ovf[0], o_zero[0],
           o_vld[0], o_rdy[0]} !== {held, 2'b10}) begin
        $display("FAIL bp_hold cyc%0d got %h vld=%b rdy=%b want %h vld=1 rdy=0",
                 i, {o_res[0], o_cout[0], o_ovf[0], o_zero[0]},
                 o_vld[0], o_rdy[0], held);
      end else n_pass++;
    end
    drv_valid = 1'b0;
    finish_op(0);
    n_chk++;
    if ({o_rdy[0], o_vld[0], o_busy[0]} !== 3'b100) begin
      $display("FAIL bp_release got rdy/vld/busy=%b%b%b want 100",
               o_rdy[0], o_vld[0], o_busy[0]);
    end else n_pass++;
    test_directed("bp_next", 16'h00FF, 16'h0F00, 3'd3, 1'b0,
                  16'h0FFF, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_run();
    sel       = 0;
    drv_a     = 16'hAAAA;
    drv_b     = 16'h5555;
    drv_op    = 3'd4;
    drv_cin   = 1'b0;
    drv_valid = 1'b1;
    step();
    drv_valid = 1'b0;
    step();
    step();
    n_chk++;
    if (o_busy[0] !== 1'b1) begin
      $display("FAIL midrun_busy got %b want 1", o_busy[0]);
    end else n_pass++;
    rst = 1'b1;
    #1;
    n_chk++;
    if ({o_rdy[0], o_vld[0], o_res[0], o_cout[0], o_ovf[0],
         o_zero[0], o_busy[0]} !== {1'b1, 1'b0, 16'h0, 4'h0}) begin
      $display("FAIL midrun_reset got rdy=%b vld=%b res=%h busy=%b want 1 0 0000 0",
               o_rdy[0], o_vld[0], o_res[0], o_busy[0]);
    end else n_pass++;
    step();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) step();
    n_chk++;
    if (o_vld[0] !== 1'b0) begin
      $display("FAIL midrun_no_result got vld=%b want 0", o_vld[0]);
    end else n_pass++;
    test_directed("post_reset_add", 16'h1234, 16'h1111, 3'd0, 1'b0,
                  16'h2345, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_random(input int k, input int w, input int ndig,
                             input int n);
    int lat, hold, mode;
    logic [15:0] a, b, er;
    logic [2:0]  op;
    logic        cin, ec, ev, ez;
    for (int i = 0; i < n; i++) begin
      a    = 16'($urandom);
      b    = 16'($urandom);
      op   = 3'($urandom_range(0, 7));
      cin  = 1'($urandom);
      mode = $urandom_range(0, 5);
      if (mode == 0) b = 16'(-a);
      if (mode == 1) b = a;
      if (mode == 2) b = ~a;
      model(w, a, b, op, cin, er, ec, ev, ez);
      do_op(k, a, b, op, cin, lat);
      n_chk++;
      if (lat !== ndig) begin
        $display("FAIL rand_latency cfg%0d op%0d got %0d want %0d",
                 k, op, lat, ndig);
      end else n_pass++;
      n_chk++;
      if ({o_res[k], o_cout[k], o_ovf[k], o_zero[k]} !== {er, ec, ev, ez}) begin
        $display("FAIL rand_result cfg%0d op%0d a=%h b=%h cin=%b got res=%h c=%b v=%b z=%b want res=%h c=%b v=%b z=%b",
                 k, op, a, b, cin, o_res[k], o_cout[k], o_ovf[k],
                 o_zero[k], er, ec, ev, ez);
      end else n_pass++;
      hold = $urandom_range(0, 2);
      for (int j = 0; j < hold; j++) step();
      n_chk++;
      if ({o_vld[k], o_rdy[k], o_res[k]} !== {2'b10, er}) begin
        $display("FAIL rand_hold cfg%0d got vld=%b rdy=%b res=%h want 1 0 %h",
                 k, o_vld[k], o_rdy[k], o_res[k], er);
      end else n_pass++;
      finish_op(k);
      n_chk++;
      if ({o_rdy[k], o_vld[k]} !== 2'b10) begin
        $display("FAIL rand_release cfg%0d got rdy=%b vld=%b want 1 0",
                 k, o_rdy[k], o_vld[k]);
      end else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_directed("add_wrap", 16'hFFFF, 16'h0001, 3'd0, 1'b0,
                  16'h0000, 1'b1, 1'b0, 1'b1);
    test_directed("sub_ovf", 16'h8000, 16'h0001, 3'd1, 1'b1,
                  16'h7FFF, 1'b1, 1'b1, 1'b0);
    test_directed("carry_op", 16'h0F0F, 16'hF0F1, 3'd6, 1'b0,
                  16'h0000, 1'b1, 1'b0, 1'b1);
    test_directed("carry_add", 16'h0F0F, 16'hF0F1, 3'd0, 1'b0,
                  16'h0000, 1'b1, 1'b0, 1'b1);
    test_directed("reserved", 16'h1234, 16'h5678, 3'd7, 1'b1,
                  16'h0000, 1'b1, 1'b0, 1'b1);
    test_backpressure();
    test_reset_mid_run();
    test_random(0, 16, 4, 1000);
    test_random(1, 16, 16, 1000);
    test_random(2, 16, 1, 1000);
    test_random(3, 8, 4, 1000);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
